// File: rtl/synth_scaler.sv
// synth_scaler: converts signed synth samples into OUT_W-bit offset-binary codes
// for the audio sampler. It applies volume attenuation and mute, and buffers the
// results in a 2-entry FIFO. The FIFO absorbs the sampler's sparse ready pulses.
// Optional build macro: SYNTH_SCALER_FADE_EN. When it is defined, the applied
// shift moves one step toward `volume` per accepted sample instead of jumping.
`timescale 1ns/1ps

module synth_scaler #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] in_sample,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             volume,
    input  logic                   mute,
    output logic [OUT_W-1:0]       out_code,
    output logic                   out_valid,
    input  logic                   out_ready
);

    // Midscale code (offset-binary zero), e.g. 512 at 10 bits.
    localparam logic [OUT_W-1:0] MID_CODE = {1'b1, {(OUT_W-1){1'b0}}};

    logic [2:0]       cur_shift;
    logic [OUT_W-1:0] conv_code;
    logic             push;
    logic             pop;

    logic [OUT_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [OUT_W-1:0] last_code;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

`ifdef SYNTH_SCALER_FADE_EN
    logic [2:0] fade_shift;

    // Step the applied shift one notch toward volume after each accepted sample.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register in the block sees the pre-edge values of the others.
        if (rst) begin
            fade_shift <= 3'd0;
        end else if (push) begin
            if (fade_shift < volume)
                fade_shift <= fade_shift + 3'd1;
            else if (fade_shift > volume)
                fade_shift <= fade_shift - 3'd1;
        end
    end

    // The sample accepted this cycle uses the pre-update fade value.
    assign cur_shift = fade_shift;
`else
    // Without fade the volume is applied directly on the accept cycle.
    assign cur_shift = volume;
`endif

    // Attenuate, keep the top OUT_W bits, and flip the sign bit to get offset binary.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; otherwise
        // a latch is inferred.
        conv_code = MID_CODE;
        if (!mute)
            conv_code = OUT_W'((in_sample >>> cur_shift) >>> (IN_W - OUT_W)) ^ MID_CODE;
    end

    // FIFO storage, pointers, occupancy, and the hold value shown while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is reset on purpose. Both entries must read
            // midscale after reset, so this small array stays in flops.
            mem[0]    <= MID_CODE;
            mem[1]    <= MID_CODE;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            last_code <= MID_CODE;
        end else begin
            if (push) begin
                mem[wr_ptr] <= conv_code;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                last_code <= mem[rd_ptr];
                rd_ptr    <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Handshake and head presentation. in_ready is low throughout reset and
    // whenever the FIFO is full, so push and pop can never coincide at count 2.
    assign in_ready  = !rst && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_code  = (count == 2'd0) ? last_code : mem[rd_ptr];

endmodule
